// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 4-bit add/subtract ALU among NUM_REQ requesters.
// Results land in a single registered response slot tagged with the requester ID.

module alu_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_op,
    output logic [3:0] o_result,
    output logic       o_carry
);
    logic [4:0] w_sum;

    // Bit 4 is the carry for add and the borrow (a < b) for subtract.
    always_comb begin
        if (i_op) begin
            w_sum = {1'b0, i_a} - {1'b0, i_b};
        end else begin
            w_sum = {1'b0, i_a} + {1'b0, i_b};
        end
    end

    assign o_result = w_sum[3:0];
    assign o_carry  = w_sum[4];
endmodule

module alu_share_arbiter #(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [3:0]           rsp_result,
    output logic                 rsp_carry
);
    logic            r_valid;
    logic [ID_W-1:0] r_id;
    logic [3:0]      r_result;
    logic            r_carry;
    logic [ID_W-1:0] r_last;

    logic            w_can_accept;
    logic            w_xfer;
    logic            w_grant_vld;
    logic [ID_W-1:0] w_grant;
    logic [ID_W:0]   w_idx;
    logic [3:0]      w_alu_a;
    logic [3:0]      w_alu_b;
    logic            w_alu_op;
    logic [3:0]      w_alu_result;
    logic            w_alu_carry;

    assign w_can_accept = !r_valid || rsp_ready;

    // Search from last+1, wrapping, for the first valid requester.
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        w_idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_last} + (ID_W+1)'(k + 1);
            if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!w_grant_vld && req_valid[w_idx[ID_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx[ID_W-1:0];
            end
        end
    end

    // Never accept while reset is asserted so the reset cycle shows no ready.
    assign w_xfer = w_grant_vld && w_can_accept && !reset;

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    // Steer the granted requester's operands into the shared ALU.
    always_comb begin
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alu_op = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_alu_a  = req_a[4*i +: 4];
                w_alu_b  = req_b[4*i +: 4];
                w_alu_op = req_op[i];
            end
        end
    end

    alu_4bit u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

    // Response slot: a push overrides a pop; a pop alone only clears valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_last   <= ID_W'(NUM_REQ - 1);
        end else if (w_xfer) begin
            r_valid  <= 1'b1;
            r_id     <= w_grant;
            r_result <= w_alu_result;
            r_carry  <= w_alu_carry;
            r_last   <= w_grant;
        end else if (rsp_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign rsp_valid  = r_valid;
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_carry  = r_carry;
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Round-robin arbiter that time-shares one alu_4bit instance between NUM_REQ requesters. Each requester presents an operation with a valid/ready handshake. The arbiter grants one request per cycle, drives the shared ALU, and registers the result into a single response slot tagged with the requester ID. It sits between the counter/sequencer clients and the shared 4-bit arithmetic resource.

Parameters:
NUM_REQ, 3, number of requesters; legal range 2..8
ID_W, $clog2(NUM_REQ), localparam; width of the requester ID

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_a  input  4*NUM_REQ  operand A; requester i uses bits [4i+3:4i]
req_b  input  4*NUM_REQ  operand B; requester i uses bits [4i+3:4i]
req_op  input  NUM_REQ  operation select; 0 = add, 1 = subtract
req_ready  output  NUM_REQ  per-requester accept; at most one bit set
rsp_valid  output  1  response slot holds a result
rsp_ready  input  1  consumer accepts the response
rsp_id  output  ID_W  index of the requester that produced the result
rsp_result  output  4  ALU result
rsp_carry  output  1  add: carry out of bit 3; subtract: borrow (1 when a < b, unsigned)

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, round-robin pointer last=NUM_REQ-1. After reset, requester 0 has highest priority.
- can_accept = !rsp_valid || rsp_ready. This gives flow-through with no bubble when the slot drains in the same cycle.
- Grant is combinational. Search req_valid starting at index (last+1) mod NUM_REQ and wrapping. The first set bit is grant g.
- req_ready[g] = can_accept. All other req_ready bits are 0. req_ready is 0 everywhere when no request is valid.
- Transfer occurs when req_valid[g] && req_ready[g]. On that edge:
  - rsp_result and rsp_carry load the ALU outputs for requester g's operands and op.
  - rsp_id loads g, rsp_valid is set to 1, and last loads g.
- ALU arithmetic is modulo 16:
  - add: result = (a+b) mod 16, carry = (a+b) > 15.
  - subtract: result = (a-b) mod 16, carry = (a < b).
- Latency: the result is visible one cycle after the accepting edge.
- Throughput is one op per cycle while rsp_ready stays high.
- Response hold: while rsp_valid && !rsp_ready, rsp_id, rsp_result and rsp_carry are frozen and no request is accepted.
- Pop without push: rsp_valid && rsp_ready with no transfer clears rsp_valid. The data registers keep their old values.
- Simultaneous pop and push: a new result replaces the old one and rsp_valid stays 1.
- last updates only on a transfer. During a stall the grant may move to a different requester; no transfer occurs, so fairness is preserved.
- Requester obligation: hold req_valid and operands stable until req_ready. The arbiter does not latch unaccepted requests.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,2,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 transfers.
- Reset mid-operation: a pending response is discarded (rsp_valid=0) and the pointer returns to NUM_REQ-1. No req_ready is asserted during the reset cycle.
- The shared ALU is driven from the granted requester's operands. When no request is valid, its inputs are don't-care and have no visible effect.

Test Plan:
1. Reset, then req_valid=3'b001, a0=4'h7, b0=4'h5, op0=0, rsp_ready=1 -> req_ready=3'b001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=4'hC, rsp_carry=0.
2. Add overflow: a1=4'hF, b1=4'h1, op1=0 on requester 1 -> rsp_result=4'h0, rsp_carry=1, rsp_id=1. Subtract: a2=4'h3, b2=4'h5, op2=1 -> rsp_result=4'hE, rsp_carry=1.
3. All three valid continuously, rsp_ready=1 for 6 cycles -> rsp_id sequence 0,1,2,0,1,2 with no idle cycle between results.
4. Backpressure: result pending with rsp_ready=0 for 3 cycles while requesters 1 and 2 are valid -> req_ready=0, rsp fields stable. When rsp_ready=1, the next grant goes to (last+1) and the old and new results swap on the same edge.
5. Reset asserted while rsp_valid=1 and all requesters valid -> the next cycle shows rsp_valid=0. The first grant after deassertion goes to requester 0.
6. Only requester 2 valid for 4 back-to-back ops, then requesters 0 and 2 valid -> requester 0 wins the next grant (pointer wrapped from 2), then requester 2.
